// File: rtl/timer_bank.sv
// timer_bank: bank of NUM_CH down-counting timers behind one word-addressed slave port.
// Optional per-channel clock prescaler is compiled in when PRESCALE_EN is defined.
module timer_bank #(
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned CNT_W     = 32,
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [29:0]       Addr,
    input  logic              WE,
    input  logic [31:0]       Din,
    output logic [31:0]       Dout,
    output logic [NUM_CH-1:0] IRQ
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_EXP  = 2'd3
    } state_e;

    localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [29:0] BASE_W = BASE_ADDR[31:2];
    localparam logic [29:0] SPAN_W = 30'(4 * NUM_CH);

    logic [29:0]       off;
    logic              hit;
    logic [CH_W-1:0]   ch_sel;
    logic [1:0]        reg_sel;
    logic [NUM_CH-1:0] ch_hit;
    logic [NUM_CH-1:0] tick;
    logic              unused_ok;

    state_e            st_q     [NUM_CH];
    state_e            st_d     [NUM_CH];
    logic [1:0]        mode_q   [NUM_CH];
    logic [1:0]        mode_d   [NUM_CH];
    logic [CNT_W-1:0]  preset_q [NUM_CH];
    logic [CNT_W-1:0]  preset_d [NUM_CH];
    logic [CNT_W-1:0]  count_q  [NUM_CH];
    logic [CNT_W-1:0]  count_d  [NUM_CH];
    logic [NUM_CH-1:0] en_q, en_d;
    logic [NUM_CH-1:0] im_q, im_d;
    logic [NUM_CH-1:0] pend_q, pend_d;
    logic [NUM_CH-1:0] irq_q, irq_d;
`ifdef PRESCALE_EN
    logic [7:0]        psc_q    [NUM_CH];
    logic [7:0]        psc_d    [NUM_CH];
    logic [7:0]        pcnt_q   [NUM_CH];
    logic [7:0]        pcnt_d   [NUM_CH];
`endif

    // Window decode; BASE_ADDR is 16-byte aligned so the low offset bits equal Addr[1:0].
    assign off       = Addr - BASE_W;
    assign hit       = (Addr >= BASE_W) && (off < SPAN_W);
    assign ch_sel    = off[CH_W+1:2];
    assign reg_sel   = Addr[1:0];
    assign unused_ok = ^{off, Din};

    // Per-channel select and count-enable tick.
    always_comb begin
        ch_hit = '0;
        tick   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            ch_hit[k] = hit && (ch_sel == CH_W'(k));
`ifdef PRESCALE_EN
            tick[k] = (pcnt_q[k] == psc_q[k]);
`else
            tick[k] = 1'b1;
`endif
        end
    end

    // Channel FSM next state, then bus writes layered on top (writes win).
    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            st_d[k]     = st_q[k];
            mode_d[k]   = mode_q[k];
            preset_d[k] = preset_q[k];
            count_d[k]  = count_q[k];
            en_d[k]     = en_q[k];
            im_d[k]     = im_q[k];
            pend_d[k]   = pend_q[k];
`ifdef PRESCALE_EN
            psc_d[k]    = psc_q[k];
            pcnt_d[k]   = pcnt_q[k];
`endif
            // W1C first so an expiry in the same cycle re-sets PEND.
            if (WE && ch_hit[k] && reg_sel == 2'd3 && Din[0]) begin
                pend_d[k] = 1'b0;
            end

            case (st_q[k])
                S_IDLE: begin
                    if (en_q[k]) begin
                        st_d[k] = S_LOAD;
                    end
                end
                S_LOAD: begin
                    count_d[k] = preset_q[k];
`ifdef PRESCALE_EN
                    pcnt_d[k]  = 8'd0;
`endif
                    st_d[k]    = S_CNT;
                end
                S_CNT: begin
                    if (!en_q[k]) begin
                        st_d[k] = S_IDLE;
                    end else if (tick[k]) begin
`ifdef PRESCALE_EN
                        pcnt_d[k] = 8'd0;
`endif
                        if (count_q[k] > CNT_W'(1)) begin
                            count_d[k] = count_q[k] - CNT_W'(1);
                        end else begin
                            count_d[k] = '0;
                            st_d[k]    = S_EXP;
                        end
                    end else begin
`ifdef PRESCALE_EN
                        pcnt_d[k] = pcnt_q[k] + 8'd1;
`endif
                    end
                end
                default: begin
                    pend_d[k] = 1'b1;
                    if (mode_q[k] == 2'b01) begin
                        st_d[k] = S_LOAD;
                    end else begin
                        en_d[k] = 1'b0;
                        st_d[k] = S_IDLE;
                    end
                end
            endcase

            if (WE && ch_hit[k] && reg_sel == 2'd0) begin
                en_d[k]   = Din[0];
                mode_d[k] = Din[2:1];
                im_d[k]   = Din[3];
`ifdef PRESCALE_EN
                psc_d[k]  = Din[15:8];
`endif
                if (!Din[0]) begin
                    st_d[k]    = S_IDLE;
                    count_d[k] = count_q[k];
                end
            end

            if (WE && ch_hit[k] && reg_sel == 2'd1) begin
                preset_d[k] = Din[CNT_W-1:0];
            end

            irq_d[k] = pend_d[k] & im_d[k];
        end
    end

    // Register read mux, zero outside the window.
    always_comb begin
        Dout = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ch_hit[k]) begin
                case (reg_sel)
`ifdef PRESCALE_EN
                    2'd0:    Dout = {16'h0, psc_q[k], 4'h0,
                                     im_q[k], mode_q[k], en_q[k]};
`else
                    2'd0:    Dout = {28'h0, im_q[k], mode_q[k], en_q[k]};
`endif
                    2'd1:    Dout = 32'(preset_q[k]);
                    2'd2:    Dout = 32'(count_q[k]);
                    default: Dout = {29'h0, st_q[k], pend_q[k]};
                endcase
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_CH; k++) begin
                st_q[k]     <= S_IDLE;
                mode_q[k]   <= '0;
                preset_q[k] <= '0;
                count_q[k]  <= '0;
`ifdef PRESCALE_EN
                psc_q[k]    <= '0;
                pcnt_q[k]   <= '0;
`endif
            end
            en_q   <= '0;
            im_q   <= '0;
            pend_q <= '0;
            irq_q  <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                st_q[k]     <= st_d[k];
                mode_q[k]   <= mode_d[k];
                preset_q[k] <= preset_d[k];
                count_q[k]  <= count_d[k];
`ifdef PRESCALE_EN
                psc_q[k]    <= psc_d[k];
                pcnt_q[k]   <= pcnt_d[k];
`endif
            end
            en_q   <= en_d;
            im_q   <= im_d;
            pend_q <= pend_d;
            irq_q  <= irq_d;
        end
    end

    assign IRQ = irq_q;

endmodule

// File: tb/tb_timer_bank.sv
// tb_timer_bank: directed scoreboard bench for timer_bank (NUM_CH=2, CNT_W=32).
// Expected read data is queued when a read is driven and popped when sampled.
module tb_timer_bank;

    localparam int NUM_CH = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [29:0]       Addr;
    logic              WE;
    logic [31:0]       Din;
    logic [31:0]       Dout;
    logic [NUM_CH-1:0] IRQ;

    int checks = 0;
    int errors = 0;

    logic [31:0] sb_q  [$];
    string       tag_q [$];

    timer_bank #(
        .NUM_CH   (NUM_CH),
        .CNT_W    (32),
        .BASE_ADDR(32'h0000_7F00)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .Addr (Addr),
        .WE   (WE),
        .Din  (Din),
        .Dout (Dout),
        .IRQ  (IRQ)
    );

    always #5 clk = ~clk;

    function automatic logic [29:0] ra(input int ch, input int r);
        return 30'h1FC0 + 30'(4 * ch + r);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr_raw(input logic [29:0] a, input logic [31:0] d);
        Addr = a;
        Din  = d;
        WE   = 1'b1;
        @(posedge clk);
        #1;
        WE   = 1'b0;
        Din  = '0;
    endtask

    task automatic wr(input int ch, input int r, input logic [31:0] d);
        wr_raw(ra(ch, r), d);
    endtask

    task automatic rd_raw(input logic [29:0] a, input logic [31:0] exp,
                          input string tag);
        sb_q.push_back(exp);
        tag_q.push_back(tag);
        Addr = a;
        WE   = 1'b0;
        #1;
        chk(tag_q.pop_front(), Dout, sb_q.pop_front());
    endtask

    task automatic rd(input int ch, input int r, input logic [31:0] exp,
                      input string tag);
        rd_raw(ra(ch, r), exp, tag);
    endtask

    task automatic irq_is(input logic [1:0] exp, input string tag);
        chk(tag, 32'(IRQ), 32'(exp));
    endtask

    initial begin
        reset = 1'b1;
        WE    = 1'b0;
        Addr  = '0;
        Din   = '0;
        step(3);
        reset = 1'b0;

        // Reset state and out-of-window accesses.
        for (int c = 0; c < NUM_CH; c++)
            for (int r = 0; r < 4; r++)
                rd(c, r, 32'h0, "rst_reg");
        irq_is(2'b00, "rst_irq");
        wr_raw(30'h1FC8, 32'hFFFF_FFFF);
        rd_raw(30'h1FC8, 32'h0, "miss_hi");
        rd_raw(30'h1FBF, 32'h0, "miss_lo");
        for (int c = 0; c < NUM_CH; c++)
            for (int r = 0; r < 4; r++)
                rd(c, r, 32'h0, "miss_noeff");
`ifndef PRESCALE_EN
        wr(1, 0, 32'h0000_FF00);
        rd(1, 0, 32'h0, "psc_ignored");
`endif

        // One-shot on ch0, PRESET=5.
        wr(0, 1, 32'd5);
        wr(0, 0, 32'h9);
        rd(0, 3, 32'h0, "t2_idle");
        step(1);
        rd(0, 3, 32'h2, "t2_load");
        step(1);
        for (int v = 5; v >= 1; v--) begin
            rd(0, 2, 32'(v), "t2_cnt");
            rd(0, 3, 32'h4, "t2_st_cnt");
            irq_is(2'b00, "t2_irq_low");
            step(1);
        end
        rd(0, 3, 32'h6, "t2_exp");
        rd(0, 2, 32'h0, "t2_cnt0");
        irq_is(2'b00, "t2_irq_pre");
        step(1);
        irq_is(2'b01, "t2_irq");
        rd(0, 3, 32'h1, "t2_pend");
        rd(0, 0, 32'h8, "t2_en_clr");
        step(3);
        irq_is(2'b01, "t2_irq_hold");
        wr(0, 3, 32'h1);
        irq_is(2'b00, "t2_irq_clr");
        rd(0, 3, 32'h0, "t2_w1c");

        // Auto-reload on ch1, PRESET=3; ch0 must stay untouched.
        wr(1, 1, 32'd3);
        wr(1, 0, 32'hB);
        step(1);
        rd(1, 3, 32'h2, "t3_load");
        step(1);
        for (int v = 3; v >= 1; v--) begin
            rd(1, 2, 32'(v), "t3_cnt");
            step(1);
        end
        rd(1, 3, 32'h6, "t3_exp");
        irq_is(2'b00, "t3_irq_pre");
        step(1);
        rd(1, 3, 32'h3, "t3_reload");
        rd(1, 2, 32'h0, "t3_cnt0");
        irq_is(2'b10, "t3_irq");
        step(1);
        for (int v = 3; v >= 1; v--) begin
            rd(1, 2, 32'(v), "t3_cnt2");
            rd(1, 3, 32'h5, "t3_st2");
            step(1);
        end
        rd(1, 3, 32'h7, "t3_exp2");
        step(1);
        rd(1, 3, 32'h3, "t3_pend_kept");
        irq_is(2'b10, "t3_irq_kept");
        rd(0, 0, 32'h8, "t3_ch0_ctrl");
        rd(0, 1, 32'h5, "t3_ch0_pre");
        rd(0, 3, 32'h0, "t3_ch0_st");
        wr(1, 0, 32'h0);
        rd(1, 3, 32'h1, "t3_stop");
        irq_is(2'b00, "t3_im_off");
        wr(1, 3, 32'h1);
        rd(1, 3, 32'h0, "t3_w1c");

        // Disable mid-count on ch0, then re-enable.
        wr(0, 1, 32'd10);
        wr(0, 0, 32'h9);
        step(2);
        rd(0, 2, 32'd10, "t4_first");
        step(6);
        rd(0, 2, 32'd4, "t4_at4");
        wr(0, 0, 32'h8);
        rd(0, 2, 32'd4, "t4_hold");
        rd(0, 3, 32'h0, "t4_idle");
        step(3);
        rd(0, 2, 32'd4, "t4_hold2");
        rd(0, 3, 32'h0, "t4_idle2");
        irq_is(2'b00, "t4_noirq");
        wr(0, 0, 32'h9);
        step(2);
        rd(0, 2, 32'd10, "t4_reload");
        rd(0, 3, 32'h4, "t4_cnt_st");
        wr(0, 0, 32'h0);

        // W1C in the expiry cycle: the set wins.
        wr(0, 1, 32'd2);
        wr(0, 0, 32'h9);
        step(4);
        rd(0, 3, 32'h6, "t5_exp");
        wr(0, 3, 32'h1);
        rd(0, 3, 32'h1, "t5_set_wins");
        irq_is(2'b01, "t5_irq");
        wr(0, 3, 32'h1);
        irq_is(2'b00, "t5_irq_clr");

        // CTRL write in the one-shot expiry cycle: written EN wins.
        wr(0, 0, 32'h9);
        step(4);
        rd(0, 3, 32'h6, "t5_exp_b");
        wr(0, 0, 32'h9);
        rd(0, 0, 32'h9, "t5_en_wins");
        rd(0, 3, 32'h1, "t5_pend_b");
        step(1);
        rd(0, 3, 32'h3, "t5_relaunch");
        wr(0, 0, 32'h0);
        wr(0, 3, 32'h1);
        rd(0, 3, 32'h0, "t5_clean");

        // PRESET=0 expires on the first CNT cycle.
        wr(0, 1, 32'd0);
        wr(0, 0, 32'h9);
        step(2);
        rd(0, 3, 32'h4, "t5_p0_cnt");
        rd(0, 2, 32'h0, "t5_p0_val");
        step(1);
        rd(0, 3, 32'h6, "t5_p0_exp");
        step(1);
        rd(0, 3, 32'h1, "t5_p0_pend");
        irq_is(2'b01, "t5_p0_irq");
        wr(0, 0, 32'h0);
        wr(0, 3, 32'h1);

        // Reset in the middle of a count.
        wr(1, 1, 32'd20);
        wr(1, 0, 32'hB);
        wr(0, 1, 32'd7);
        step(4);
        rd(1, 2, 32'd17, "t5_mid");
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        for (int c = 0; c < NUM_CH; c++)
            for (int r = 0; r < 4; r++)
                rd(c, r, 32'h0, "t5_rst_reg");
        irq_is(2'b00, "t5_rst_irq");
        step(3);
        rd(1, 2, 32'h0, "t5_rst_cnt");
        rd(1, 3, 32'h0, "t5_rst_idle");

`ifdef PRESCALE_EN
        // Prescaler: PSC=3 gives one decrement every 4 cycles.
        wr(0, 1, 32'd2);
        wr(0, 0, 32'h0309);
        rd(0, 0, 32'h0309, "t6_ctrl");
        step(2);
        for (int c = 3; c <= 10; c++) begin
            rd(0, 2, (c < 7) ? 32'd2 : 32'd1, "t6_cnt");
            step(1);
        end
        rd(0, 3, 32'h6, "t6_exp");
        wr(0, 0, 32'h0);
        wr(0, 3, 32'h1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
